alu_8bit_seq: RTL and testbench
===============================

Name: alu_8bit_seq

Overview:
8-bit execution unit that directly feeds flags_register. It performs single-cycle add, subtract and logic operations, plus 8-iteration sequential unsigned MUL and DIV. It drives alu_result, carry_out, overflow_out and a one-cycle update_flags strobe into the flag register. A start/busy/done handshake connects it to the control unit.

Parameters:
WIDTH, 8, operand and result width; only 8 is supported, and the iteration count equals WIDTH.

Ports:
clk  in  1  clock; all state changes on the rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  request; sampled only when busy=0
op  in  4  operation code (alu_pkg)
operand_a  in  8  first operand / dividend / multiplicand
operand_b  in  8  second operand / divisor / multiplier
carry_flag_in  in  1  current CF from flags_register (ADC, SBB, INC, DEC)
busy  out  1  MUL/DIV in progress
done  out  1  one-cycle pulse: results valid
alu_result  out  8  result low byte / quotient
result_hi  out  8  MUL high byte / DIV remainder; 0 for other ops
carry_out  out  1  CF to flags_register
overflow_out  out  1  OF to flags_register
update_flags  out  1  one-cycle strobe to flags_register
div_error  out  1  one-cycle pulse: divide by zero

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs and internal registers are 0. Reset mid-MUL/DIV aborts the operation with no done pulse.
- States: IDLE, ITER.
- Start acceptance: start=1 while IDLE is accepted at edge E. start while busy=1 is ignored and not queued. start in the cycle done=1 is accepted, because the block is IDLE then.
- Single-cycle ops (ADD, ADC, SUB, SBB, AND, OR, XOR, INC, DEC):
  - Results are registered at E.
  - done=1 and update_flags=1 for exactly the one cycle after E.
  - busy stays 0; state stays IDLE.
- ADD/ADC: 9-bit sum a+b(+CF). carry_out = bit 8. overflow_out = a[7]==b[7] && r[7]!=a[7].
- SUB/SBB: a-b(-CF). carry_out = borrow. overflow_out = a[7]!=b[7] && r[7]!=a[7].
- INC/DEC: operand_a±1. carry_out = carry_flag_in (CF preserved). OF is set on 0x7F→0x80 (INC) and 0x80→0x7F (DEC).
- AND/OR/XOR: carry_out=0, overflow_out=0.
- MUL (unsigned shift-add):
  - Operands load at E; state goes to ITER with counter=8; busy=1.
  - One iteration per edge E+1..E+8. The iteration at E+8 writes outputs, returns to IDLE and sets busy=0.
  - busy is high for exactly 8 cycles. done=1 and update_flags=1 in the cycle after E+8.
  - Outputs: {result_hi, alu_result} = a*b. carry_out = overflow_out = (result_hi != 0).
- DIV (unsigned restoring):
  - Same timing as MUL. alu_result = quotient, result_hi = remainder.
  - update_flags=0; carry_out and overflow_out hold their previous values.
- DIV with operand_b=0:
  - No iteration; busy stays 0.
  - done=1 and div_error=1 in the cycle after E; update_flags=0.
  - alu_result and result_hi hold their previous values.
- Undefined op codes: treated as a NOP. done=1 the cycle after E, update_flags=0, outputs hold.
- Output hold: alu_result, result_hi, carry_out and overflow_out hold until the next done. done, update_flags and div_error are never high for more than one cycle.
- Operand capture: operand_a, operand_b and carry_flag_in are captured at E. Later changes do not affect an operation in flight.

Decomposition:
- Shared package alu_pkg:
  - alu_op_t enum: ADD=0, ADC=1, SUB=2, SBB=3, AND=4, OR=5, XOR=6, INC=7, DEC=8, MUL=9, DIV=10.
  - State enum alu_state_t {IDLE, ITER}.
  - Constant ALU_ITERS = 8.
- One sub-module, alu_muldiv_iter: holds the shared accumulator/shift register and counter, and performs one MUL or DIV step per cycle.
- The single-cycle datapath and FSM stay in the top module.

Test Plan:
- ADD 0x7F+0x01 → done one cycle after start; alu_result=0x80, carry_out=0, overflow_out=1, update_flags=1 for 1 cycle.
- SUB 0x00-0x01 → alu_result=0xFF, carry_out=1, overflow_out=0. INC 0xFF with carry_flag_in=1 → alu_result=0x00, carry_out=1, overflow_out=0.
- MUL 0x10*0x20 → busy high for 8 cycles, start pulsed at cycle 3 ignored; alu_result=0x00, result_hi=0x02, carry_out=overflow_out=1; done on cycle 9 after start.
- DIV 0xC8/0x07 → alu_result=0x1C, result_hi=0x04, update_flags=0, done on cycle 9. DIV 0x55/0x00 → done=1, div_error=1 the next cycle, busy never high, outputs unchanged.
- rst asserted at iteration 4 of a MUL → busy, done and all outputs are 0 immediately. A following ADD 0x01+0x01 gives 0x02 one cycle later.
- Back-to-back: a new start held during the MUL done cycle is accepted. Its ADD result appears exactly one cycle later with no lost strobe.

Source files
------------

// File: rtl/alu_pkg.sv
// ============================================================================
// Module      : alu_pkg
// Description : Shared operation codes, FSM states and iteration count for
//               the 8-bit sequential ALU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    typedef enum logic [3:0] {
        ADD = 4'd0,
        ADC = 4'd1,
        SUB = 4'd2,
        SBB = 4'd3,
        AND = 4'd4,
        OR  = 4'd5,
        XOR = 4'd6,
        INC = 4'd7,
        DEC = 4'd8,
        MUL = 4'd9,
        DIV = 4'd10
    } alu_op_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ITER = 1'b1
    } alu_state_t;

    localparam int ALU_ITERS = 8;

    function automatic logic is_iterative(input logic [3:0] op);
        return (op == MUL) || (op == DIV);
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_muldiv_iter.sv
// ============================================================================
// Module      : alu_muldiv_iter
// Description : Shared shift register / accumulator performing one unsigned
//               shift-add multiply or restoring divide step per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_step,
    input  logic             i_is_div,
    input  logic [WIDTH-1:0] i_operand_a,
    input  logic [WIDTH-1:0] i_operand_b,
    output logic [WIDTH-1:0] o_next_lo,
    output logic [WIDTH-1:0] o_next_hi,
    output logic             o_last
);

    localparam int c_CNT_W = $clog2(ALU_ITERS + 1);

    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_m;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_div;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;

    // MUL: {acc,q} shifts right with the multiplicand added in when q[0]=1.
    // DIV: {acc,q} shifts left; the trial subtraction's borrow bit decides restore.
    always_comb begin
        w_sum   = {1'b0, r_acc} + {1'b0, r_m};
        w_shift = {r_acc, r_q[WIDTH-1]};
        w_diff  = w_shift - {1'b0, r_m};
        if (r_div) begin
            if (!w_diff[WIDTH]) begin
                o_next_hi = w_diff[WIDTH-1:0];
                o_next_lo = {r_q[WIDTH-2:0], 1'b1};
            end else begin
                o_next_hi = w_shift[WIDTH-1:0];
                o_next_lo = {r_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (r_q[0]) begin
                o_next_hi = w_sum[WIDTH:1];
                o_next_lo = {w_sum[0], r_q[WIDTH-1:1]};
            end else begin
                o_next_hi = {1'b0, r_acc[WIDTH-1:1]};
                o_next_lo = {r_acc[0], r_q[WIDTH-1:1]};
            end
        end
        o_last = (r_cnt == c_CNT_W'(1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
            r_q   <= '0;
            r_m   <= '0;
            r_cnt <= '0;
            r_div <= 1'b0;
        end else if (i_load) begin
            r_acc <= '0;
            r_q   <= i_operand_a;
            r_m   <= i_operand_b;
            r_cnt <= c_CNT_W'(ALU_ITERS);
            r_div <= i_is_div;
        end else if (i_step && (r_cnt != '0)) begin
            r_acc <= o_next_hi;
            r_q   <= o_next_lo;
            r_cnt <= r_cnt - 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_8bit_seq.sv
// ============================================================================
// Module      : alu_8bit_seq
// Description : 8-bit execution unit: single-cycle arithmetic/logic plus
//               8-iteration unsigned MUL/DIV with start/busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_8bit_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             carry_flag_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] result_hi,
    output logic             carry_out,
    output logic             overflow_out,
    output logic             update_flags,
    output logic             div_error
);

    alu_state_t       r_state;
    logic             r_is_div;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_res;
    logic             w_cin;
    logic             w_cf;
    logic             w_of;
    logic             w_single;
    logic             w_div_zero;
    logic             w_load;
    logic             w_last;
    logic [WIDTH-1:0] w_md_lo;
    logic [WIDTH-1:0] w_md_hi;

    always_comb begin
        w_cin    = ((op == ADC) || (op == SBB)) ? carry_flag_in : 1'b0;
        w_sum    = {1'b0, operand_a} + {1'b0, operand_b} + {{WIDTH{1'b0}}, w_cin};
        w_diff   = {1'b0, operand_a} - {1'b0, operand_b} - {{WIDTH{1'b0}}, w_cin};
        w_res    = '0;
        w_cf     = 1'b0;
        w_of     = 1'b0;
        w_single = 1'b1;
        case (op)
            ADD, ADC: begin
                w_res = w_sum[WIDTH-1:0];
                w_cf  = w_sum[WIDTH];
                w_of  = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) &&
                        (w_sum[WIDTH-1] != operand_a[WIDTH-1]);
            end
            SUB, SBB: begin
                w_res = w_diff[WIDTH-1:0];
                w_cf  = w_diff[WIDTH];
                w_of  = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) &&
                        (w_diff[WIDTH-1] != operand_a[WIDTH-1]);
            end
            AND: w_res = operand_a & operand_b;
            OR:  w_res = operand_a | operand_b;
            XOR: w_res = operand_a ^ operand_b;
            INC: begin
                w_res = operand_a + WIDTH'(1);
                w_cf  = carry_flag_in;
                w_of  = (operand_a == {1'b0, {(WIDTH-1){1'b1}}});
            end
            DEC: begin
                w_res = operand_a - WIDTH'(1);
                w_cf  = carry_flag_in;
                w_of  = (operand_a == {1'b1, {(WIDTH-1){1'b0}}});
            end
            default: w_single = 1'b0;
        endcase
        w_div_zero = (op == DIV) && (operand_b == '0);
        w_load     = (r_state == IDLE) && start && is_iterative(op) && !w_div_zero;
    end

    alu_muldiv_iter #(
        .WIDTH       (WIDTH)
    ) u_muldiv (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load),
        .i_step      (r_state == ITER),
        .i_is_div    (op == DIV),
        .i_operand_a (operand_a),
        .i_operand_b (operand_b),
        .o_next_lo   (w_md_lo),
        .o_next_hi   (w_md_hi),
        .o_last      (w_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_is_div     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            alu_result   <= '0;
            result_hi    <= '0;
            carry_out    <= 1'b0;
            overflow_out <= 1'b0;
            update_flags <= 1'b0;
            div_error    <= 1'b0;
        end else begin
            done         <= 1'b0;
            update_flags <= 1'b0;
            div_error    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (w_single) begin
                            alu_result   <= w_res;
                            result_hi    <= '0;
                            carry_out    <= w_cf;
                            overflow_out <= w_of;
                            done         <= 1'b1;
                            update_flags <= 1'b1;
                        end else if (w_div_zero) begin
                            done      <= 1'b1;
                            div_error <= 1'b1;
                        end else if (is_iterative(op)) begin
                            r_state  <= ITER;
                            busy     <= 1'b1;
                            r_is_div <= (op == DIV);
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                ITER: begin
                    // The final step's next values are the finished product or quotient.
                    if (w_last) begin
                        r_state    <= IDLE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        alu_result <= w_md_lo;
                        result_hi  <= w_md_hi;
                        if (!r_is_div) begin
                            carry_out    <= (w_md_hi != '0);
                            overflow_out <= (w_md_hi != '0);
                            update_flags <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_8bit_seq.sv
// ============================================================================
// Module      : tb_alu_8bit_seq
// Description : Self-checking bench for alu_8bit_seq against an arithmetic
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_8bit_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] op = 4'd0;
    logic [7:0] operand_a = 8'd0;
    logic [7:0] operand_b = 8'd0;
    logic       carry_flag_in = 1'b0;
    logic       busy, done, carry_out, overflow_out, update_flags, div_error;
    logic [7:0] alu_result, result_hi;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state (held outputs) and per-op expectations
    logic [7:0] m_res = 0, m_hi = 0;
    logic       m_cf = 0, m_of = 0;
    int         e_lat, e_busy;
    logic       e_uf, e_de;

    // observations of the last operation
    int         ob_lat, ob_busy;
    logic       ob_uf, ob_de, ob_cf, ob_of, ob_early;
    logic [7:0] ob_res, ob_hi;

    alu_8bit_seq #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .operand_a(operand_a), .operand_b(operand_b), .carry_flag_in(carry_flag_in),
        .busy(busy), .done(done), .alu_result(alu_result), .result_hi(result_hi),
        .carry_out(carry_out), .overflow_out(overflow_out),
        .update_flags(update_flags), .div_error(div_error)
    );

    always #5 clk = ~clk;

    task automatic model_op(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b, input logic c);
        int ua, ub, sa, sb, r, s, ci;
        ua = a; ub = b;
        sa = (ua > 127) ? ua - 256 : ua;
        sb = (ub > 127) ? ub - 256 : ub;
        e_lat = 1; e_busy = 0; e_uf = 1'b1; e_de = 1'b0;
        ci = ((o == 4'd1) || (o == 4'd3)) ? int'(c) : 0;
        case (o)
            4'd0, 4'd1: begin
                r = ua + ub + ci; s = sa + sb + ci;
                m_res = r[7:0]; m_hi = 0; m_cf = (r > 255); m_of = (s > 127) || (s < -128);
            end
            4'd2, 4'd3: begin
                r = ua - ub - ci; s = sa - sb - ci;
                m_res = r[7:0]; m_hi = 0; m_cf = (r < 0); m_of = (s > 127) || (s < -128);
            end
            4'd4: begin m_res = a & b; m_hi = 0; m_cf = 0; m_of = 0; end
            4'd5: begin m_res = a | b; m_hi = 0; m_cf = 0; m_of = 0; end
            4'd6: begin m_res = a ^ b; m_hi = 0; m_cf = 0; m_of = 0; end
            4'd7: begin r = ua + 1; m_res = r[7:0]; m_hi = 0; m_cf = c; m_of = (sa + 1 > 127); end
            4'd8: begin r = ua - 1; m_res = r[7:0]; m_hi = 0; m_cf = c; m_of = (sa - 1 < -128); end
            4'd9: begin
                r = ua * ub;
                m_res = r[7:0]; m_hi = r[15:8]; m_cf = (r > 255); m_of = (r > 255);
                e_lat = 9; e_busy = 8;
            end
            4'd10: begin
                e_uf = 1'b0;
                if (ub == 0) begin
                    e_de = 1'b1;
                end else begin
                    r = ua / ub; s = ua % ub;
                    m_res = r[7:0]; m_hi = s[7:0];
                    e_lat = 9; e_busy = 8;
                end
            end
            default: e_uf = 1'b0;
        endcase
    endtask

    // Starts an op at the next edge, scrambles the inputs afterwards, and
    // observes until done (bounded). Optionally pulses start at sample 'poke'.
    task automatic do_op(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b, input logic c, input int poke);
        start = 1'b1; op = o; operand_a = a; operand_b = b; carry_flag_in = c;
        @(posedge clk); #1;
        start = 1'b0; op = 4'($urandom); operand_a = 8'($urandom);
        operand_b = 8'($urandom); carry_flag_in = 1'($urandom);
        ob_lat = 0; ob_busy = 0; ob_early = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (busy) ob_busy++;
            if (done) begin
                ob_lat = k; ob_uf = update_flags; ob_de = div_error;
                ob_res = alu_result; ob_hi = result_hi; ob_cf = carry_out; ob_of = overflow_out;
                break;
            end
            if (update_flags || div_error) ob_early = 1'b1;
            if (k == poke) begin start = 1'b1; op = 4'd0; end
            @(posedge clk); #1;
            start = 1'b0;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, done, update_flags, div_error, carry_out, overflow_out} !== 6'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b required 000000", {busy, done, update_flags, div_error, carry_out, overflow_out});
        end
        n_checks++;
        if ({alu_result, result_hi} !== 16'h0) begin
            n_fail++; $display("FAIL reset_data: got %h required 0000", {alu_result, result_hi});
        end
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL idle_after_reset: done=%b busy=%b required 0 0", done, busy);
        end
    endtask

    task automatic test_arith_directed();
        model_op(4'd0, 8'h7F, 8'h01, 1'b0);
        do_op(4'd0, 8'h7F, 8'h01, 1'b0, 0);
        n_checks++;
        if (ob_lat !== 1 || {ob_res, ob_cf, ob_of, ob_uf} !== {8'h80, 1'b0, 1'b1, 1'b1}) begin
            n_fail++; $display("FAIL add_7f_01: lat=%0d res=%h cf=%b of=%b uf=%b required 1 80 0 1 1", ob_lat, ob_res, ob_cf, ob_of, ob_uf);
        end
        @(posedge clk); #1;
        n_checks++;
        if (update_flags !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL add_strobe_width: uf=%b done=%b required 0 0", update_flags, done);
        end
        model_op(4'd2, 8'h00, 8'h01, 1'b0);
        do_op(4'd2, 8'h00, 8'h01, 1'b0, 0);
        n_checks++;
        if ({ob_res, ob_cf, ob_of} !== {8'hFF, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL sub_00_01: res=%h cf=%b of=%b required ff 1 0", ob_res, ob_cf, ob_of);
        end
        model_op(4'd7, 8'hFF, 8'h00, 1'b1);
        do_op(4'd7, 8'hFF, 8'h00, 1'b1, 0);
        n_checks++;
        if ({ob_res, ob_cf, ob_of} !== {8'h00, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL inc_ff: res=%h cf=%b of=%b required 00 1 0", ob_res, ob_cf, ob_of);
        end
    endtask

    task automatic test_mul();
        model_op(4'd9, 8'h10, 8'h20, 1'b0);
        do_op(4'd9, 8'h10, 8'h20, 1'b0, 3);
        n_checks++;
        if (ob_lat !== 9 || ob_busy !== 8 || ob_early !== 1'b0) begin
            n_fail++; $display("FAIL mul_timing: lat=%0d busy=%0d early=%b required 9 8 0", ob_lat, ob_busy, ob_early);
        end
        n_checks++;
        if ({ob_hi, ob_res, ob_cf, ob_of, ob_uf} !== {8'h02, 8'h00, 1'b1, 1'b1, 1'b1}) begin
            n_fail++; $display("FAIL mul_10_20: hi=%h res=%h cf=%b of=%b uf=%b required 02 00 1 1 1", ob_hi, ob_res, ob_cf, ob_of, ob_uf);
        end
        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL mul_poke_not_queued: done=%b busy=%b required 0 0", done, busy);
        end
    endtask

    task automatic test_div();
        model_op(4'd10, 8'hC8, 8'h07, 1'b0);
        do_op(4'd10, 8'hC8, 8'h07, 1'b0, 0);
        n_checks++;
        if (ob_lat !== 9 || {ob_res, ob_hi, ob_uf} !== {8'h1C, 8'h04, 1'b0} || {ob_cf, ob_of} !== {m_cf, m_of}) begin
            n_fail++; $display("FAIL div_c8_07: lat=%0d q=%h r=%h uf=%b cf=%b of=%b required 9 1c 04 0 %b %b", ob_lat, ob_res, ob_hi, ob_uf, ob_cf, ob_of, m_cf, m_of);
        end
        model_op(4'd10, 8'h55, 8'h00, 1'b0);
        do_op(4'd10, 8'h55, 8'h00, 1'b0, 0);
        n_checks++;
        if (ob_lat !== 1 || ob_busy !== 0 || ob_de !== 1'b1 || ob_uf !== 1'b0) begin
            n_fail++; $display("FAIL div_zero_ctrl: lat=%0d busy=%0d de=%b uf=%b required 1 0 1 0", ob_lat, ob_busy, ob_de, ob_uf);
        end
        n_checks++;
        if ({ob_res, ob_hi} !== {m_res, m_hi}) begin
            n_fail++; $display("FAIL div_zero_hold: got %h required %h", {ob_res, ob_hi}, {m_res, m_hi});
        end
    endtask

    task automatic test_random();
        logic [3:0] o;
        logic [7:0] a, b;
        logic       c;
        for (int i = 0; i < 60; i++) begin
            o = 4'($urandom_range(0, 15));
            a = 8'($urandom); b = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            c = 1'($urandom);
            model_op(o, a, b, c);
            do_op(o, a, b, c, 0);
            n_checks++;
            if (ob_lat !== e_lat || ob_busy !== e_busy || ob_early !== 1'b0) begin
                n_fail++; $display("FAIL rnd_timing op=%0d a=%h b=%h: lat=%0d busy=%0d early=%b required %0d %0d 0", o, a, b, ob_lat, ob_busy, ob_early, e_lat, e_busy);
            end
            n_checks++;
            if ({ob_res, ob_hi, ob_cf, ob_of} !== {m_res, m_hi, m_cf, m_of}) begin
                n_fail++; $display("FAIL rnd_data op=%0d a=%h b=%h c=%b: got %h %h %b %b required %h %h %b %b", o, a, b, c, ob_res, ob_hi, ob_cf, ob_of, m_res, m_hi, m_cf, m_of);
            end
            n_checks++;
            if (ob_uf !== e_uf || ob_de !== e_de) begin
                n_fail++; $display("FAIL rnd_strobes op=%0d: uf=%b de=%b required %b %b", o, ob_uf, ob_de, e_uf, e_de);
            end
            @(posedge clk); #1;
            n_checks++;
            if ({done, update_flags, div_error} !== 3'b000) begin
                n_fail++; $display("FAIL rnd_pulse op=%0d: done/uf/de=%b required 000", o, {done, update_flags, div_error});
            end
        end
    endtask

    task automatic test_reset_mid();
        model_op(4'd0, 8'h33, 8'h44, 1'b0);
        do_op(4'd0, 8'h33, 8'h44, 1'b0, 0);
        start = 1'b1; op = 4'd9; operand_a = 8'h10; operand_b = 8'h20;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, done, update_flags, div_error, carry_out, overflow_out, alu_result, result_hi} !== 22'h0) begin
            n_fail++; $display("FAIL reset_mid_mul: busy=%b done=%b res=%h hi=%h required all 0", busy, done, alu_result, result_hi);
        end
        m_res = 0; m_hi = 0; m_cf = 0; m_of = 0;
        @(negedge clk) rst = 1'b0;
        model_op(4'd0, 8'h01, 8'h01, 1'b0);
        do_op(4'd0, 8'h01, 8'h01, 1'b0, 0);
        n_checks++;
        if (ob_lat !== 1 || ob_res !== 8'h02 || ob_uf !== 1'b1) begin
            n_fail++; $display("FAIL add_after_reset: lat=%0d res=%h uf=%b required 1 02 1", ob_lat, ob_res, ob_uf);
        end
    endtask

    task automatic test_back_to_back();
        int  k;
        logic got_done;
        model_op(4'd9, 8'hFF, 8'hFF, 1'b0);
        start = 1'b1; op = 4'd9; operand_a = 8'hFF; operand_b = 8'hFF;
        @(posedge clk); #1;
        start = 1'b0;
        got_done = 1'b0;
        for (k = 1; k <= 20 && !got_done; k++) begin
            if (done) got_done = 1'b1;
            else begin @(posedge clk); #1; end
        end
        n_checks++;
        if (!got_done || {alu_result, result_hi, update_flags} !== {m_res, m_hi, 1'b1}) begin
            n_fail++; $display("FAIL b2b_mul: done_seen=%b res=%h hi=%h uf=%b required 1 %h %h 1", got_done, alu_result, result_hi, update_flags, m_res, m_hi);
        end
        model_op(4'd1, 8'h12, 8'h34, 1'b1);
        start = 1'b1; op = 4'd1; operand_a = 8'h12; operand_b = 8'h34; carry_flag_in = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++;
        if ({done, update_flags, busy, alu_result, result_hi} !== {1'b1, 1'b1, 1'b0, m_res, 8'h00}) begin
            n_fail++; $display("FAIL b2b_adc: done=%b uf=%b busy=%b res=%h hi=%h required 1 1 0 %h 00", done, update_flags, busy, alu_result, result_hi, m_res);
        end
    endtask

    initial begin
        test_reset();
        test_arith_directed();
        test_mul();
        test_div();
        test_random();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
